wavelet_tap_buffer: RTL and testbench
=====================================

Name: wavelet_tap_buffer

Overview:
- Upstream sample-collection stage for the fir wavelet filter.
- Accepts one signed sample per handshake and maintains a NUM_ELEM-deep shift window, presented as the packed taps bus that fir consumes.
- Issues a one-cycle start pulse to fir once the window is full, then every STRIDE accepted samples, so the filter bank can decimate.

Parameters:
- BITS_PER_ELEM, 8, width of each signed sample/tap element
- NUM_ELEM, 7, window depth; must match the fir instance
- STRIDE, 1, accepted samples between start pulses once full (1 = every sample; legal range >= 1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  i_sample is valid this cycle
- i_sample  input  BITS_PER_ELEM  signed input sample
- i_flush  input  1  synchronous clear of window and counters
- o_ready  output  1  block accepts a sample this cycle
- o_taps  output  NUM_ELEM*BITS_PER_ELEM  packed window to fir taps; element k at [BITS_PER_ELEM*k +: BITS_PER_ELEM]
- o_start_calc  output  1  one-cycle pulse to fir i_start_calc
- o_full  output  1  window holds NUM_ELEM valid samples

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Everything else is synchronous to the rising edge of clk.
- Reset (rst_n low, any time, including mid-window): o_taps = 0, o_start_calc = 0, o_full = 0, fill counter = 0, stride counter = 0. o_ready is 0 while reset is asserted.
- o_ready: 1 in every cycle out of reset, except the cycle in which i_flush = 1.
- Accept: a sample is accepted when i_valid && o_ready.
- Shift on accept, at the same edge:
  - element 0 <= i_sample;
  - element k <= element k-1, for k = 1..NUM_ELEM-1;
  - element NUM_ELEM-1 is discarded.
- Fill counter:
  - Range 0..NUM_ELEM; increments on accept and saturates at NUM_ELEM.
  - o_full = (fill == NUM_ELEM), registered.
- Stride counter:
  - Range 0..STRIDE-1; it advances only on accepts that leave the window full (post-shift fill == NUM_ELEM).
  - On such an accept: if stride_cnt == 0, o_start_calc is 1 in the next cycle. Then stride_cnt <= (stride_cnt == STRIDE-1) ? 0 : stride_cnt+1.
  - Result: first pulse is generated by accept number NUM_ELEM, then one pulse every STRIDE accepts.
- Timing:
  - o_start_calc is registered. It is high for exactly one cycle, the cycle immediately after the accepting edge.
  - In that cycle o_taps already holds the updated window, so fir samples a consistent window.
  - Latency from accept to pulse is 1 cycle. There is no pulse without an accept.
- Idle cycle (no accept): o_taps, the counters and o_full hold; o_start_calc = 0.
- Flush (i_flush = 1): at the next edge, o_taps = 0, fill = 0, stride_cnt = 0, o_full = 0, o_start_calc = 0.
  - Flush has priority over a simultaneous i_valid. That sample is not accepted (o_ready = 0 that cycle).
  - A flush in the same cycle as an o_start_calc pulse does not cancel the pulse already being driven; the following cycle is 0.
- Back-to-back accepts every cycle are supported, with STRIDE=1 giving a pulse every cycle. The block never stalls its input except during flush.
- Arithmetic: samples are stored bit-exact and never scaled or sign-modified. Counter widths are $clog2(NUM_ELEM+1) and $clog2(STRIDE)+1.

Test Plan:
- Reset: assert rst_n=0 mid-stream with NUM_ELEM=7 partly filled (4 samples) -> o_taps=0, o_full=0, o_start_calc=0 immediately; 7 new samples are needed before the first pulse.
- Fill and first pulse (STRIDE=1): accept 1,2,3,4,5,6,7 on consecutive cycles -> no pulse after samples 1-6. One cycle after sample 7: o_start_calc=1, o_full=1, o_taps elements 0..6 = 7,6,5,4,3,2,1.
- Streaming (STRIDE=1): accept 8 next cycle -> pulse again; elements 0..6 = 8,7,6,5,4,3,2; sample 1 dropped.
- Decimation (STRIDE=2): accept 10 samples -> pulses only after accepts 7 and 9. A gap of idle cycles between accepts 8 and 9 does not change pulse placement.
- Signed values: accept 0x80 (-128) and 0x7F (+127) -> stored bit-exact in o_taps; through the fir instance, the sum matches a reference model.
- Flush: i_flush=1 together with i_valid after 5 samples -> sample not accepted, o_ready=0 that cycle, window cleared; the next 7 accepts are required before a pulse.

Source files
------------

// File: rtl/wavelet_tap_buffer.sv
// ============================================================================
// Module   : wavelet_tap_buffer
// Brief    : Sample window feeding the fir wavelet filter; pulses start_calc
//            once full and then every STRIDE accepted samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module wavelet_tap_buffer #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 7,
  parameter int STRIDE        = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  input  logic [BITS_PER_ELEM-1:0]          i_sample,
  input  logic                              i_flush,
  output logic                              o_ready,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
  output logic                              o_start_calc,
  output logic                              o_full
);

  localparam int FILL_W   = $clog2(NUM_ELEM + 1);
  localparam int STRIDE_W = $clog2(STRIDE) + 1;

  localparam logic [FILL_W-1:0]   c_FILL_MAX    = FILL_W'(NUM_ELEM);
  localparam logic [FILL_W-1:0]   c_FILL_LAST   = FILL_W'(NUM_ELEM - 1);
  localparam logic [STRIDE_W-1:0] c_STRIDE_LAST = STRIDE_W'(STRIDE - 1);

  logic [BITS_PER_ELEM-1:0] r_win [NUM_ELEM];
  logic [FILL_W-1:0]        r_fill;
  logic [STRIDE_W-1:0]      r_stride;

  logic                     w_accept;
  logic                     w_full_after;
  logic [FILL_W-1:0]        w_fill_next;
  logic [STRIDE_W-1:0]      w_stride_next;

  // Input is only refused during reset or a flush cycle.
  assign o_ready  = rst_n & ~i_flush;
  assign w_accept = i_valid & o_ready;

  // True when the accept being taken leaves the window full.
  assign w_full_after  = (r_fill >= c_FILL_LAST);
  assign w_fill_next   = (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;
  assign w_stride_next = (r_stride == c_STRIDE_LAST) ? '0 : r_stride + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ELEM; k++) r_win[k] <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < NUM_ELEM; k++) r_win[k] <= '0;
    end else if (w_accept) begin
      r_win[0] <= i_sample;
      for (int k = 1; k < NUM_ELEM; k++) r_win[k] <= r_win[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill       <= '0;
      r_stride     <= '0;
      o_full       <= 1'b0;
      o_start_calc <= 1'b0;
    end else if (i_flush) begin
      r_fill       <= '0;
      r_stride     <= '0;
      o_full       <= 1'b0;
      o_start_calc <= 1'b0;
    end else begin
      o_start_calc <= 1'b0;
      if (w_accept) begin
        r_fill <= w_fill_next;
        o_full <= (w_fill_next == c_FILL_MAX);
        if (w_full_after) begin
          o_start_calc <= (r_stride == '0);
          r_stride     <= w_stride_next;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_pack
    assign o_taps[k*BITS_PER_ELEM +: BITS_PER_ELEM] = r_win[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_wavelet_tap_buffer.sv
// ============================================================================
// Module   : tb_wavelet_tap_buffer
// Brief    : Scoreboard bench for wavelet_tap_buffer with STRIDE=1 and STRIDE=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wavelet_tap_buffer;

  localparam int B = 8;
  localparam int N = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic [B-1:0]   i_sample = '0;
  logic           i_flush = 1'b0;

  logic           ready1, start1, full1;
  logic [N*B-1:0] taps1;
  logic           ready2, start2, full2;
  logic [N*B-1:0] taps2;

  wavelet_tap_buffer #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sample(i_sample), .i_flush(i_flush),
    .o_ready(ready1), .o_taps(taps1), .o_start_calc(start1), .o_full(full1)
  );

  wavelet_tap_buffer #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sample(i_sample), .i_flush(i_flush),
    .o_ready(ready2), .o_taps(taps2), .o_start_calc(start2), .o_full(full2)
  );

  always #5 clk = ~clk;

  logic [N*B-1:0] q1 [$];
  logic [N*B-1:0] q2 [$];
  logic [B-1:0]   win [N];
  int             n_checks = 0;
  int             n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*B-1:0] pack_win();
    logic [N*B-1:0] p;
    for (int k = 0; k < N; k++) p[k*B +: B] = win[k];
    return p;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) win[k] = '0;
  endtask

  // p1/p2: hand-determined whether each DUT must pulse after this accept.
  task automatic send(input logic [B-1:0] s, input bit p1, input bit p2);
    i_valid  = 1'b1;
    i_sample = s;
    for (int k = N - 1; k > 0; k--) win[k] = win[k-1];
    win[0] = s;
    if (p1) q1.push_back(pack_win());
    if (p2) q2.push_back(pack_win());
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    fork
      forever begin
        @(negedge clk);
        if (start1) begin
          if (q1.size() == 0) chk("dut1 unexpected pulse", 64'd1, 64'd0);
          else chk("dut1 pulse taps", taps1, q1.pop_front());
        end
        if (start2) begin
          if (q2.size() == 0) chk("dut2 unexpected pulse", 64'd1, 64'd0);
          else chk("dut2 pulse taps", taps2, q2.pop_front());
        end
      end
    join_none

    // Power-on reset
    #1;
    chk("reset ready", ready1, 0);
    chk("reset taps", taps1, 0);
    chk("reset full", full1, 0);
    chk("reset start", start1, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after reset", ready1, 1);

    // Partial fill, then asynchronous reset mid-window
    send(8'd1, 0, 0); send(8'd2, 0, 0); send(8'd3, 0, 0); send(8'd4, 0, 0);
    chk("partial taps", taps1, 64'h01020304);
    rst_n = 1'b0;
    #1;
    chk("async reset taps", taps1, 0);
    chk("async reset taps dut2", taps2, 0);
    chk("async reset full", full1, 0);
    chk("async reset ready", ready1, 0);
    clear_model();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to first pulse
    send(8'd1, 0, 0); send(8'd2, 0, 0); send(8'd3, 0, 0);
    send(8'd4, 0, 0); send(8'd5, 0, 0); send(8'd6, 0, 0);
    chk("not full at 6", full1, 0);
    send(8'd7, 1, 1);
    chk("first window", taps1, 64'h01020304050607);
    chk("full at 7", full1, 1);
    chk("start after 7", start1, 1);

    // Streaming; dut2 skips accept 8
    send(8'd8, 1, 0);
    chk("window after 8", taps1, 64'h02030405060708);
    idle(1);
    chk("idle no pulse", start1, 0);
    idle(2);
    chk("idle hold taps", taps1, 64'h02030405060708);
    send(8'd9, 1, 1);
    send(8'd10, 1, 0);

    // Signed extremes stored bit-exact
    send(8'h80, 1, 1);
    send(8'h7F, 1, 0);
    chk("signed elems", taps1[15:0], 64'h807F);
    chk("signed elems dut2", taps2[15:0], 64'h807F);

    // Flush in the pulse cycle: pulse survives, window cleared next edge
    i_flush = 1'b1;
    #1;
    chk("flush ready", ready1, 0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    clear_model();
    chk("post-flush start", start1, 0);
    chk("post-flush taps", taps1, 0);
    chk("post-flush full", full1, 0);

    // Flush with simultaneous valid after 5 samples
    send(8'd21, 0, 0); send(8'd22, 0, 0); send(8'd23, 0, 0);
    send(8'd24, 0, 0); send(8'd25, 0, 0);
    i_valid = 1'b1; i_sample = 8'd99; i_flush = 1'b1;
    #1;
    chk("flush+valid ready", ready1, 0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush+valid taps", taps1, 0);
    chk("flush+valid full", full2, 0);

    send(8'd31, 0, 0); send(8'd32, 0, 0); send(8'd33, 0, 0);
    send(8'd34, 0, 0); send(8'd35, 0, 0); send(8'd36, 0, 0);
    send(8'd37, 1, 1);
    chk("refill window", taps1, 64'h1F202122232425);
    send(8'd38, 1, 0);
    idle(2);

    chk("dut1 pending pulses", q1.size(), 0);
    chk("dut2 pending pulses", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
